// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, functs,
// ALU codes, state encoding and the per-state Moore control bundle.
package mips_ctrl_pkg;

    localparam int OP_W     = 6;
    localparam int FUNCT_W  = 6;
    localparam int ALUCTL_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore decode; unused state codes fall through to all-zero enables.
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b = SRCB_FOUR;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            S_DECODE:  c.alu_src_b = SRCB_IMMSH2;
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_SUB;
                c.pc_src    = PCSRC_ALUOUT;
                c.branch    = 1'b1;
            end
            S_ADDIWB:  c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_src   = PCSRC_JUMP;
                c.pc_write = 1'b1;
            end
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU function decode from ALUOp and funct; flags functs the ALU does not support.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int FUNCT_WIDTH   = 6,
    parameter int ALUCTRL_WIDTH = 3
) (
    input  logic [1:0]               alu_op,
    input  logic [FUNCT_WIDTH-1:0]   funct,
    output logic [ALUCTRL_WIDTH-1:0] alu_control,
    output logic                     funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   funct_illegal = 1'b1;
                endcase
            end
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Main FSM for the multicycle MIPS datapath; Moore enables are registered
// from the next state so they change cleanly on the clock edge.
//
// state   | meaning
// FETCH   | read instruction at PC into IR, PC <= PC+4
// DECODE  | read registers, precompute branch target
// MEMADR  | lw/sw effective address
// MEMRD   | lw data read
// MEMWB   | lw writeback to rt
// MEMWR   | sw data write
// EXECUTE | R-type ALU operation
// ALUWB   | R-type writeback to rd
// BRANCH  | beq compare, conditional PC load
// ADDIEX  | addi ALU operation
// ADDIWB  | addi writeback to rt
// JUMP    | PC <= jump target
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int OP_WIDTH      = 6,
    parameter int FUNCT_WIDTH   = 6,
    parameter int ALUCTRL_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [OP_WIDTH-1:0]      Op,
    input  logic [FUNCT_WIDTH-1:0]   Funct,
    input  logic                     Zero,
    output logic                     IorD,
    output logic                     MemWrite,
    output logic                     IRWrite,
    output logic                     RegDst,
    output logic                     MemtoReg,
    output logic                     RegWrite,
    output logic                     ALUSrcA,
    output logic [1:0]               ALUSrcB,
    output logic [ALUCTRL_WIDTH-1:0] ALUControl,
    output logic [1:0]               PCSrc,
    output logic                     PCEn,
    output logic                     IllegalInstr
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   op_illegal;
    logic   funct_illegal;

    always_comb begin
        state_d    = S_FETCH;
        op_illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        op_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
        ctrl_d = state_ctrl(state_d);
    end

    // Async reset lands directly on the FETCH decode so no write enable survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    mips_alu_decoder #(
        .FUNCT_WIDTH   (FUNCT_WIDTH),
        .ALUCTRL_WIDTH (ALUCTRL_WIDTH)
    ) u_alu_decoder (
        .alu_op        (ctrl_q.alu_op),
        .funct         (Funct),
        .alu_control   (ALUControl),
        .funct_illegal (funct_illegal)
    );

    assign IorD         = ctrl_q.iord;
    assign MemWrite     = ctrl_q.mem_write;
    assign IRWrite      = ctrl_q.ir_write;
    assign RegDst       = ctrl_q.reg_dst;
    assign MemtoReg     = ctrl_q.mem_to_reg;
    assign RegWrite     = ctrl_q.reg_write;
    assign ALUSrcA      = ctrl_q.alu_src_a;
    assign ALUSrcB      = ctrl_q.alu_src_b;
    assign PCSrc        = ctrl_q.pc_src;
    assign PCEn         = ctrl_q.pc_write | (ctrl_q.branch & Zero);
    assign IllegalInstr = op_illegal | ((state_q == S_EXECUTE) & funct_illegal);

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench: per-instruction behavioural model compared every cycle,
// plus directed literal checks at the interesting steps.
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       PCEn, IllegalInstr;

    int n_pass  = 0;
    int n_total = 0;
    int phase;

    mips_multicycle_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Op           (Op),
        .Funct        (Funct),
        .Zero         (Zero),
        .IorD         (IorD),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegDst       (RegDst),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUControl   (ALUControl),
        .PCSrc        (PCSrc),
        .PCEn         (PCEn),
        .IllegalInstr (IllegalInstr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluctrl;
        logic [1:0] pcsrc;
        logic       pcen, illegal;
    } exp_t;

    function automatic int instr_len(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    // Expected outputs for cycle 'ph' of an instruction (0 = fetch cycle).
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input int ph);
        exp_t e;
        e = '0;
        e.aluctrl = 3'b010;
        if (ph == 0) begin
            e.irwrite = 1; e.alusrcb = 2'b01; e.pcen = 1;
        end else if (ph == 1) begin
            e.alusrcb = 2'b11;
            e.illegal = (instr_len(op) == 2);
        end else begin
            case (op)
                6'b100011, 6'b101011: begin
                    if (ph == 2) begin e.alusrca = 1; e.alusrcb = 2'b10; end
                    else if (op == 6'b101011) begin e.iord = 1; e.memwrite = 1; end
                    else if (ph == 3) e.iord = 1;
                    else begin e.memtoreg = 1; e.regwrite = 1; end
                end
                6'b000000: begin
                    if (ph == 2) begin
                        e.alusrca = 1;
                        case (fn)
                            6'h20: e.aluctrl = 3'b010;
                            6'h22: e.aluctrl = 3'b110;
                            6'h24: e.aluctrl = 3'b000;
                            6'h25: e.aluctrl = 3'b001;
                            6'h2a: e.aluctrl = 3'b111;
                            default: e.illegal = 1;
                        endcase
                    end else begin
                        e.regdst = 1; e.regwrite = 1;
                    end
                end
                6'b000100: begin
                    e.alusrca = 1; e.aluctrl = 3'b110; e.pcsrc = 2'b01; e.pcen = z;
                end
                6'b001000: begin
                    if (ph == 2) begin e.alusrca = 1; e.alusrcb = 2'b10; end
                    else e.regwrite = 1;
                end
                default: begin
                    e.pcsrc = 2'b10; e.pcen = 1;
                end
            endcase
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= 0;
        else        phase <= (phase + 1 >= instr_len(Op)) ? 0 : phase + 1;
    end

    always @(negedge clk) begin
        exp_t e, a;
        if (rst_n === 1'b1) begin
            e = model(Op, Funct, Zero, phase);
            a = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, ALUControl, PCSrc, PCEn, IllegalInstr};
            n_total++;
            if (a === e) n_pass++;
            else $display("FAIL model op=%b funct=%b phase=%0d actual=%h expected=%h",
                          Op, Funct, phase, a, e);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z);
        Op = op; Funct = fn; Zero = z;
        repeat (instr_len(op)) step();
    endtask

    initial begin
        rst_n = 1'b0; Op = 6'b0; Funct = 6'b0; Zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irwrite", {7'd0, IRWrite}, 8'd1);
        chk("rst_pcen", {7'd0, PCEn}, 8'd1);
        chk("rst_aluctrl", {5'd0, ALUControl}, 8'd2);
        chk("rst_alusrcb", {6'd0, ALUSrcB}, 8'd1);
        chk("rst_regwrite", {7'd0, RegWrite}, 8'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // lw: 5 cycles
        Op = 6'b100011; Funct = 6'h00; Zero = 1'b0;
        step(); step(); step();
        chk("lw_memrd_iord", {7'd0, IorD}, 8'd1);
        chk("lw_memrd_aluctrl", {5'd0, ALUControl}, 8'd2);
        step();
        chk("lw_memwb_regwrite", {7'd0, RegWrite}, 8'd1);
        chk("lw_memwb_memtoreg", {7'd0, MemtoReg}, 8'd1);
        chk("lw_memwb_irwrite", {7'd0, IRWrite}, 8'd0);
        step();
        chk("lw_back_fetch", {7'd0, IRWrite}, 8'd1);

        run(6'b101011, 6'h00, 1'b0);

        // R-type sub then slt
        Op = 6'b000000; Funct = 6'b100010;
        step(); step();
        chk("r_sub_aluctrl", {5'd0, ALUControl}, 8'd6);
        step();
        chk("r_aluwb_regdst", {7'd0, RegDst}, 8'd1);
        chk("r_aluwb_regwrite", {7'd0, RegWrite}, 8'd1);
        step();
        chk("r_back_fetch", {7'd0, IRWrite}, 8'd1);
        Funct = 6'b101010;
        step(); step();
        chk("r_slt_aluctrl", {5'd0, ALUControl}, 8'd7);
        step(); step();
        run(6'b000000, 6'b100100, 1'b1);
        run(6'b000000, 6'b100101, 1'b0);

        // beq taken / not taken
        Op = 6'b000100; Funct = 6'h11; Zero = 1'b1;
        step(); step();
        chk("beq_t_pcen", {7'd0, PCEn}, 8'd1);
        chk("beq_t_pcsrc", {6'd0, PCSrc}, 8'd1);
        chk("beq_t_aluctrl", {5'd0, ALUControl}, 8'd6);
        step();
        chk("beq_t_fetch", {7'd0, IRWrite}, 8'd1);
        Zero = 1'b0;
        step(); step();
        chk("beq_nt_pcen", {7'd0, PCEn}, 8'd0);
        Zero = 1'b1; #1;
        chk("beq_zero_path", {7'd0, PCEn}, 8'd1);
        Zero = 1'b0; #1;
        step();
        chk("beq_nt_fetch", {7'd0, IRWrite}, 8'd1);

        // addi
        Op = 6'b001000; Funct = 6'h3f;
        step(); step();
        chk("addi_alusrcb", {6'd0, ALUSrcB}, 8'd2);
        step();
        chk("addi_wb_regdst", {7'd0, RegDst}, 8'd0);
        chk("addi_wb_regwrite", {7'd0, RegWrite}, 8'd1);
        step();

        // j
        Op = 6'b000010;
        step(); step();
        chk("j_pcsrc", {6'd0, PCSrc}, 8'd2);
        chk("j_pcen", {7'd0, PCEn}, 8'd1);
        step();
        chk("j_fetch", {7'd0, IRWrite}, 8'd1);

        // illegal opcode
        Op = 6'b111111;
        step();
        chk("illop_pulse", {7'd0, IllegalInstr}, 8'd1);
        chk("illop_memwrite", {7'd0, MemWrite}, 8'd0);
        step();
        chk("illop_pulse_end", {7'd0, IllegalInstr}, 8'd0);
        chk("illop_fetch", {7'd0, IRWrite}, 8'd1);

        // illegal funct
        Op = 6'b000000; Funct = 6'b000111;
        step();
        chk("illfn_decode_quiet", {7'd0, IllegalInstr}, 8'd0);
        step();
        chk("illfn_pulse", {7'd0, IllegalInstr}, 8'd1);
        chk("illfn_aluctrl", {5'd0, ALUControl}, 8'd2);
        step();
        chk("illfn_aluwb", {7'd0, RegWrite}, 8'd1);
        chk("illfn_pulse_end", {7'd0, IllegalInstr}, 8'd0);
        step();

        // reset asserted mid-EXECUTE
        Op = 6'b000000; Funct = 6'b100010;
        step(); step();
        chk("pre_rst_alusrca", {7'd0, ALUSrcA}, 8'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_irwrite", {7'd0, IRWrite}, 8'd1);
        chk("mid_rst_pcen", {7'd0, PCEn}, 8'd1);
        chk("mid_rst_aluctrl", {5'd0, ALUControl}, 8'd2);
        chk("mid_rst_alusrca", {7'd0, ALUSrcA}, 8'd0);
        chk("mid_rst_regwrite", {7'd0, RegWrite}, 8'd0);
        @(posedge clk);
        #1;
        chk("held_rst_irwrite", {7'd0, IRWrite}, 8'd1);
        #1 rst_n = 1'b1;

        run(6'b100011, 6'h00, 1'b0);
        run(6'b000000, 6'b100000, 1'b0);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
